// File: rtl/soc_system_resettaken_poll_ctrl.sv
// -----------------------------------------------------------------------------
// soc_system_resettaken_poll_ctrl
//
// Avalon-MM master that services the 4-word "resettaken" PIO slave. After each
// idle interval it reads the edge-capture register (word 3). When a capture is
// set, it clears the capture with a write of 1 and counts the event. It then
// samples the live input level (word 0). The event count, the last level and a
// one-cycle event pulse are published to fabric logic.
//
// The slave has no waitrequest and a fixed, registered read latency. Each read
// holds its address after the chipselect cycle, so the slave's readdata stays
// valid while this block waits for it.
//
// Ports
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   enable          polling enable, level-sensitive
//   clear_count     one-cycle synchronous request to zero event_count
//   avm_address     PIO word address (holds its last value when idle)
//   avm_chipselect  PIO chipselect
//   avm_write_n     PIO write strobe, active-low
//   avm_writedata   PIO write data
//   avm_readdata    PIO readdata (registered in the slave)
//   event_pulse     one-cycle pulse per serviced edge capture
//   event_count     saturating count of serviced captures
//   in_level        last sampled in_port level
//   busy            high while a poll sequence is in progress
// -----------------------------------------------------------------------------
module soc_system_resettaken_poll_ctrl #(
   parameter int POLL_INTERVAL = 1024,   // 1..65535 idle cycles between polls
   parameter int READ_LATENCY  = 1,      // 1..3
   parameter int COUNT_W       = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               clear_count,
   output logic [1:0]         avm_address,
   output logic               avm_chipselect,
   output logic               avm_write_n,
   output logic [31:0]        avm_writedata,
   input  logic [31:0]        avm_readdata,
   output logic               event_pulse,
   output logic [COUNT_W-1:0] event_count,
   output logic               in_level,
   output logic               busy
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT       = 3'd1,
      S_RD_EC      = 3'd2,
      S_RD_EC_WAIT = 3'd3,
      S_CLR        = 3'd4,
      S_RD_LV      = 3'd5,
      S_RD_LV_WAIT = 3'd6
   } state_t;

   localparam logic [15:0] IVL_LOAD = 16'(POLL_INTERVAL - 1);
   // The edge-capture wait counts down from READ_LATENCY to 0 inclusive.
   // The level wait lasts exactly READ_LATENCY cycles.
   localparam logic [1:0]  LAT_EC   = 2'(READ_LATENCY);
   localparam logic [1:0]  LAT_LV   = 2'(READ_LATENCY - 1);
   localparam logic [1:0]  ADDR_LV  = 2'd0;
   localparam logic [1:0]  ADDR_EC  = 2'd3;

   state_t               state_q, state_d;
   logic [15:0]          ivl_q, ivl_d;
   logic [1:0]           lat_q, lat_d;
   logic [1:0]           addr_q, addr_d;
   logic                 cs_q, cs_d;
   logic                 wn_q, wn_d;
   logic [31:0]          wd_q, wd_d;
   logic                 pulse_q, pulse_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 level_q, level_d;
   logic                 busy_q, busy_d;

   // Only bit 0 of both PIO words carries information.
   logic unused_rdata_s;
   assign unused_rdata_s = ^avm_readdata[31:1];

   // Next-state, interval/latency counters and captured level.
   always_comb begin
      state_d = state_q;
      ivl_d   = ivl_q;
      lat_d   = lat_q;
      level_d = level_q;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_WAIT;
               ivl_d   = IVL_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (ivl_q == 16'd0) begin
               state_d = S_RD_EC;
            end else begin
               ivl_d = ivl_q - 16'd1;
            end
         end
         S_RD_EC: begin
            state_d = S_RD_EC_WAIT;
            lat_d   = LAT_EC;
         end
         S_RD_EC_WAIT: begin
            if (lat_q == 2'd0) begin
               if (avm_readdata[0]) begin
                  state_d = S_CLR;
               end else begin
                  state_d = S_RD_LV;
               end
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         S_CLR: begin
            state_d = S_RD_LV;
         end
         S_RD_LV: begin
            state_d = S_RD_LV_WAIT;
            lat_d   = LAT_LV;
         end
         S_RD_LV_WAIT: begin
            if (lat_q == 2'd0) begin
               level_d = avm_readdata[0];
               // A sequence always runs to completion; enable only matters here.
               if (enable) begin
                  state_d = S_WAIT;
                  ivl_d   = IVL_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Bus and status outputs are decoded from the state being entered.
   // Registering them makes each output coincide with its state.
   always_comb begin
      addr_d  = addr_q;
      cs_d    = 1'b0;
      wn_d    = 1'b1;
      wd_d    = 32'd0;
      pulse_d = 1'b0;
      busy_d  = 1'b1;
      case (state_d)
         S_RD_EC: begin
            addr_d = ADDR_EC;
            cs_d   = 1'b1;
         end
         S_CLR: begin
            addr_d  = ADDR_EC;
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            wd_d    = 32'h0000_0001;
            pulse_d = 1'b1;
         end
         S_RD_LV: begin
            addr_d = ADDR_LV;
            cs_d   = 1'b1;
         end
         S_RD_EC_WAIT, S_RD_LV_WAIT: begin
            busy_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // Saturating event counter; a clear request wins over a same-cycle increment.
   always_comb begin
      if (clear_count) begin
         count_d = {COUNT_W{1'b0}};
      end else if ((state_d == S_CLR) && (count_q != {COUNT_W{1'b1}})) begin
         count_d = count_q + COUNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // State, counters and all registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ivl_q   <= 16'd0;
         lat_q   <= 2'd0;
         addr_q  <= 2'd0;
         cs_q    <= 1'b0;
         wn_q    <= 1'b1;
         wd_q    <= 32'd0;
         pulse_q <= 1'b0;
         count_q <= {COUNT_W{1'b0}};
         level_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ivl_q   <= ivl_d;
         lat_q   <= lat_d;
         addr_q  <= addr_d;
         cs_q    <= cs_d;
         wn_q    <= wn_d;
         wd_q    <= wd_d;
         pulse_q <= pulse_d;
         count_q <= count_d;
         level_q <= level_d;
         busy_q  <= busy_d;
      end
   end

   assign avm_address    = addr_q;
   assign avm_chipselect = cs_q;
   assign avm_write_n    = wn_q;
   assign avm_writedata  = wd_q;
   assign event_pulse    = pulse_q;
   assign event_count    = count_q;
   assign in_level       = level_q;
   assign busy           = busy_q;

endmodule

// File: doc/soc_system_resettaken_poll_ctrl.md
Name: soc_system_resettaken_poll_ctrl

Overview:
- Avalon-MM master that sequences the 4-word resettaken PIO slave; no waitrequest on the slave, fixed registered read latency.
- Periodically reads the edge-capture register (word 3) and clears it by writing 1 when set. Counts captured rising edges.
- Samples the live input level (word 0) after every poll. Publishes count, level and a one-cycle event pulse to fabric logic, so software does not have to poll the PIO.

Parameters:
- POLL_INTERVAL, 1024: idle cycles between the end of one poll sequence and the start of the next. Legal range 1..65535.
- READ_LATENCY, 1: cycles from read-address presentation to valid readdata. Legal range 1..3.
- COUNT_W, 16: width of event_count.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  polling enable, level-sensitive
- clear_count  in  1  synchronous one-cycle request to zero event_count
- avm_address  out  2  PIO word address
- avm_chipselect  out  1  PIO chipselect
- avm_write_n  out  1  PIO write strobe, active-low
- avm_writedata  out  32  PIO write data
- avm_readdata  in  32  PIO readdata (registered in the slave)
- event_pulse  out  1  one-cycle pulse per serviced edge capture
- event_count  out  COUNT_W  saturating count of serviced captures
- in_level  out  1  last sampled in_port level
- busy  out  1  high while a poll sequence is in progress (any state other than IDLE/WAIT)

Behaviour:
- Reset values: avm_address=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0, event_pulse=0, event_count=0, in_level=0, busy=0. FSM goes to IDLE and the interval counter is cleared.
- FSM states and transitions:
  - IDLE: if enable, load the interval counter with POLL_INTERVAL-1 and go to WAIT.
  - WAIT: decrement the counter. At 0 go to RD_EC. If enable drops, go to IDLE.
  - RD_EC: drive address=3, chipselect=1, write_n=1 for 1 cycle. Start the latency counter at READ_LATENCY.
  - RD_EC_WAIT: count down. On expiry, sample avm_readdata[0]. If 1 go to CLR, else go to RD_LV.
  - CLR: drive address=3, chipselect=1, write_n=0, writedata=32'h1 for exactly 1 cycle. In the same cycle, assert event_pulse and increment event_count. Go to RD_LV.
  - RD_LV: drive address=0, chipselect=1, write_n=1 for 1 cycle. Go to RD_LV_WAIT.
  - RD_LV_WAIT: after READ_LATENCY cycles, capture avm_readdata[0] into in_level. Go to IDLE if enable is low, else to WAIT (reload counter).
- All bus outputs are registered. Outside active cycles: chipselect=0, write_n=1, writedata=0, address holds its last value.
- Minimum sequence length at READ_LATENCY=1: 5 cycles without a capture, 6 with a capture (RD_EC through RD_LV_WAIT).
- enable deassert mid-sequence: the sequence always completes through RD_LV_WAIT. It is never aborted, so a pending clear is never dropped.
- event_count saturates at all-ones and does not wrap.
- clear_count has priority over the CLR increment in the same cycle: the count becomes 0 and the pulse still fires.
- Edge coincident with the clear write: the slave gives the clear priority and that edge is lost. This is accepted and documented behaviour; in_level still reflects the new level.
- Reset asserted mid-sequence: all outputs return to reset values asynchronously. Any in-flight write is abandoned. The next enabled poll re-reads edge capture, so no state is lost on the slave side.
- busy=1 in RD_EC, RD_EC_WAIT, CLR, RD_LV and RD_LV_WAIT.

Test Plan:
- Reset, enable=1, POLL_INTERVAL=4, in_port held 0 -> first RD_EC chipselect at cycle 5 after enable. No write ever issued. event_count stays 0. Polls repeat every 4+5 cycles.
- Single in_port 0->1 rise while in WAIT -> next poll issues exactly one write addr=3 data=1. event_pulse high 1 cycle. event_count=1. in_level=1. The following poll issues no write.
- Three separated rises, then clear_count pulse coincident with the third CLR -> count reads 2, then 0. Three event_pulses observed.
- Preload the count near saturation (COUNT_W=4), apply 20 rises -> event_count holds 4'hF with no wrap. Pulses continue.
- Drop enable during RD_EC_WAIT with a capture pending -> CLR write and RD_LV still occur, then the FSM goes to IDLE. chipselect stays 0 thereafter.
- Assert reset_n=0 during CLR -> write_n returns to 1 and chipselect to 0 with no clock edge. After release and enable, the pending capture is cleared on the next poll and the count becomes 1.
